lcd_decay_scheduler: RTL and testbench

- Time-multiplexed controller for the LCD segment persistence (decay) model.
- On each 1 kHz tick it walks all 72 W/W' segment cells (9 digits x 4 bits x 2 planes), one cell per clock, and updates a 5-bit decay counter per cell.
- It derives each cell's displayed on/off state and hands a frame-coherent copy to the segment renderer at vblank.
- Sits between the CPU-side W/W' latches and the `segments` renderer, in place of a fully parallel decay update.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_decay_step.sv | 25 ++
 rtl/lcd_decay_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_lcd_decay_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, constants and cell-index helpers for the LCD decay scheduler.
// Cell index layout: plane*36 + digit*4 + bit, plane 0 = W', plane 1 = W.
package lcd_pkg;

    localparam int NUM_DIGITS      = 9;
    localparam int BITS_PER_DIGIT  = 4;
    localparam int CELLS_PER_PLANE = NUM_DIGITS * BITS_PER_DIGIT;
    localparam int NUM_CELLS       = 2 * CELLS_PER_PLANE;

    typedef logic [4:0] decay_t;
    typedef logic [6:0] cell_idx_t;

    localparam decay_t    DECAY_MAX    = 5'd31;
    localparam decay_t    DECAY_THRESH = 5'd16;
    localparam cell_idx_t LAST_CELL    = cell_idx_t'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } lcd_decay_state_t;

    typedef struct packed {
        logic       plane;
        logic [3:0] digit;
        logic [1:0] bit_sel;
    } cell_addr_t;

    // Build a flat cell index from plane/digit/bit coordinates.
    function automatic cell_idx_t cell_pack(input cell_addr_t addr);
        return cell_idx_t'(7'(addr.plane) * 7'd36 + 7'(addr.digit) * 7'd4 + 7'(addr.bit_sel));
    endfunction

    // Split a flat cell index back into plane/digit/bit coordinates.
    function automatic cell_addr_t cell_unpack(input cell_idx_t idx);
        cell_addr_t addr;
        cell_idx_t  rem;
        addr.plane   = (idx >= cell_idx_t'(CELLS_PER_PLANE));
        rem          = addr.plane ? idx - cell_idx_t'(CELLS_PER_PLANE) : idx;
        addr.digit   = rem[5:2];
        addr.bit_sel = rem[1:0];
        return addr;
    endfunction

endpackage

// File: rtl/lcd_decay_step.sv
// One decay update for a single cell: saturating +1 when driven, saturating
// -1 when not, plus the display bit taken from the pre-update value.
module lcd_decay_step
    import lcd_pkg::*;
(
    input  decay_t decay,
    input  logic   on,
    output decay_t decay_next,
    output logic   display
);

    // Saturating step; holds at 0 and DECAY_MAX so the count never wraps.
    always_comb begin
        // NOTE: default first so every path assigns decay_next; no latch.
        decay_next = decay;
        if (on && (decay < DECAY_MAX)) begin
            decay_next = decay + 5'd1;
        end else if (!on && (decay != '0)) begin
            decay_next = decay - 5'd1;
        end
    end

    assign display = (decay > DECAY_THRESH);

endmodule

// File: rtl/lcd_decay_scheduler.sv
// Time-multiplexed LCD segment decay scheduler. Each 1 kHz tick walks all 72
// W/W' cells, one per clock, and hands a frame-coherent display copy to the
// renderer at vblank.
// Build option: define LCD_DECAY_EN for the decay scan; without it the W
// latches pass straight through to the working state on each tick.
module lcd_decay_scheduler
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        divider_1khz,
    input  logic [35:0] w_prime_bits,
    input  logic [35:0] w_main_bits,
    input  logic        vblank_int,
    output logic [35:0] cache_w_prime_bits,
    output logic [35:0] cache_w_main_bits,
    output logic        busy,
    output logic        scan_done,
    output logic        overrun
);

    lcd_decay_state_t state, state_next;

    logic                 prev_divider;
    logic                 prev_vblank;
    logic                 tick_rise;
    logic                 vblank_rise;
    logic [NUM_CELLS-1:0] work;
    logic [NUM_CELLS-1:0] cache;
    logic                 pending;

    assign tick_rise   = divider_1khz & ~prev_divider;
    assign vblank_rise = vblank_int & ~prev_vblank;

    assign cache_w_prime_bits = cache[CELLS_PER_PLANE-1:0];
    assign cache_w_main_bits  = cache[NUM_CELLS-1:CELLS_PER_PLANE];

`ifdef LCD_DECAY_EN
    logic [NUM_CELLS-1:0] shadow;
    cell_idx_t            idx;
    decay_t               decay_mem [NUM_CELLS];
    decay_t               step_next;
    logic                 step_display;

    lcd_decay_step u_step (
        .decay      (decay_mem[idx]),
        .on         (shadow[idx]),
        .decay_next (step_next),
        .display    (step_display)
    );
`endif

    // Edge detectors for the tick divider and vblank level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_divider <= 1'b0;
            prev_vblank  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            prev_divider <= divider_1khz;
            prev_vblank  <= vblank_int;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        scan_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick_rise) begin
`ifdef LCD_DECAY_EN
                    state_next = ST_SCAN;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef LCD_DECAY_EN
            ST_SCAN: begin
                busy = 1'b1;
                if (idx == LAST_CELL) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                scan_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef LCD_DECAY_EN
    // Tick snapshot of the W latches and the scan cell pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            idx    <= '0;
        end else if (state == ST_IDLE && tick_rise) begin
            shadow <= {w_main_bits, w_prime_bits};
            idx    <= '0;
        end else if (state == ST_SCAN) begin
            idx <= idx + 7'd1;
        end
    end

    // Per-cell decay counters, one updated per scan cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: counters live in flops, so a reset loop is legal and required.
            for (int i = 0; i < NUM_CELLS; i++) begin
                decay_mem[i] <= '0;
            end
        end else if (state == ST_SCAN) begin
            decay_mem[idx] <= step_next;
        end
    end

    // Working display state; uses the pre-update decay, so it lags by one tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work <= '0;
        end else if (state == ST_SCAN) begin
            work[idx] <= step_display;
        end
    end

    // Sticky overrun: a tick arriving mid-scan is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (tick_rise && state != ST_IDLE) begin
            overrun <= 1'b1;
        end
    end
`else
    // Working display state follows the W latches directly on each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work <= '0;
        end else if (state == ST_IDLE && tick_rise) begin
            work <= {w_main_bits, w_prime_bits};
        end
    end

    assign overrun = 1'b0;
`endif

    // Vblank handoff: copy immediately when idle, otherwise defer to the end
    // of DONE so a partially scanned frame is never exposed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache   <= '0;
            pending <= 1'b0;
        end else if (state == ST_DONE) begin
            if (pending || vblank_rise) begin
                cache <= work;
            end
            pending <= 1'b0;
        end else if (vblank_rise) begin
            if (state == ST_IDLE) begin
                cache <= work;
            end else begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_decay_scheduler.sv
// Self-checking bench for lcd_decay_scheduler. Covers both builds: with
// LCD_DECAY_EN it exercises the decay scan, otherwise the pass-through path.
module tb_lcd_decay_scheduler;
    import lcd_pkg::*;

`ifdef LCD_DECAY_EN
    localparam int LAT      = 73;
    localparam bit EXP_BUSY = 1'b1;
`else
    localparam int LAT      = 1;
    localparam bit EXP_BUSY = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        divider_1khz;
    logic [35:0] w_prime_bits;
    logic [35:0] w_main_bits;
    logic        vblank_int;
    logic [35:0] cache_w_prime_bits;
    logic [35:0] cache_w_main_bits;
    logic        busy;
    logic        scan_done;
    logic        overrun;

    decay_t step_decay;
    logic   step_on;
    decay_t step_next;
    logic   step_disp;

    int checks = 0;
    int errors = 0;

    lcd_decay_scheduler dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .divider_1khz       (divider_1khz),
        .w_prime_bits       (w_prime_bits),
        .w_main_bits        (w_main_bits),
        .vblank_int         (vblank_int),
        .cache_w_prime_bits (cache_w_prime_bits),
        .cache_w_main_bits  (cache_w_main_bits),
        .busy               (busy),
        .scan_done          (scan_done),
        .overrun            (overrun)
    );

    lcd_decay_step u_ref_step (
        .decay      (step_decay),
        .on         (step_on),
        .decay_next (step_next),
        .display    (step_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        decay_t decay;
        logic   on;
        decay_t exp_next;
        logic   exp_disp;
    } step_vec_t;

    typedef struct {
        logic [35:0] w_prime;
        logic [35:0] w_main;
    } pat_vec_t;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] cache_vec();
        return {cache_w_main_bits, cache_w_prime_bits};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        divider_1khz = 1'b0;
        vblank_int   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic vblank_pulse();
        @(negedge clk);
        vblank_int = 1'b1;
        @(negedge clk);
        vblank_int = 1'b0;
    endtask

    // Raise the tick (optionally with vblank), wait for scan_done, return in IDLE.
    task automatic tick_wait(input string name, input bit vb);
        int n = 0;
        @(negedge clk);
        divider_1khz = 1'b1;
        vblank_int   = vb;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                divider_1khz = 1'b0;
                vblank_int   = 1'b0;
                check({name, "_busy"}, 72'(busy), 72'(EXP_BUSY));
            end
            if (scan_done) break;
        end
        check({name, "_lat"}, 72'(n), 72'(LAT));
        @(negedge clk);
    endtask

    task automatic ticks(input string name, input int count);
        for (int k = 0; k < count; k++) begin
            tick_wait(name, 1'b0);
        end
    endtask

    initial begin
        step_vec_t   steps [10];
        pat_vec_t    pats  [3];
        logic [71:0] expv;
        logic [71:0] prevv;
        int          n;
        int          done_cnt;
        bit          partial_seen;

        steps[0] = '{5'd0,  1'b0, 5'd0,  1'b0};
        steps[1] = '{5'd0,  1'b1, 5'd1,  1'b0};
        steps[2] = '{5'd16, 1'b1, 5'd17, 1'b0};
        steps[3] = '{5'd17, 1'b0, 5'd16, 1'b1};
        steps[4] = '{5'd31, 1'b1, 5'd31, 1'b1};
        steps[5] = '{5'd31, 1'b0, 5'd30, 1'b1};
        steps[6] = '{5'd30, 1'b1, 5'd31, 1'b1};
        steps[7] = '{5'd1,  1'b0, 5'd0,  1'b0};
        steps[8] = '{5'd16, 1'b0, 5'd15, 1'b0};
        steps[9] = '{5'd17, 1'b1, 5'd18, 1'b1};

        pats[0] = '{36'h0_0000_0001, 36'h8_0000_0000};
        pats[1] = '{36'hA_5A5A_5A5A, 36'h5_A5A5_A5A5};
        pats[2] = '{36'hF_FFFF_FFFF, 36'h0_0000_0000};

        reset_n      = 1'b0;
        divider_1khz = 1'b0;
        vblank_int   = 1'b0;
        w_prime_bits = '0;
        w_main_bits  = '0;
        step_decay   = '0;
        step_on      = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cache", cache_vec(), 72'd0);
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_done", 72'(scan_done), 72'd0);
        check("rst_overrun", 72'(overrun), 72'd0);
        reset_n = 1'b1;

        // Single-cell step vectors.
        for (int i = 0; i < 10; i++) begin
            step_decay = steps[i].decay;
            step_on    = steps[i].on;
            #1;
            check($sformatf("step%0d_next", i), 72'(step_next), 72'(steps[i].exp_next));
            check($sformatf("step%0d_disp", i), 72'(step_disp), 72'(steps[i].exp_disp));
        end

`ifdef LCD_DECAY_EN
        // All-zero tick: decays stay 0, latency 73, outputs stay 0.
        tick_wait("zero_tick", 1'b0);
        vblank_pulse();
        check("zero_cache", cache_vec(), 72'd0);

        // W' bit 0 on: display follows decay > 16 with one tick of lag.
        do_reset();
        w_prime_bits = 36'h1;
        w_main_bits  = '0;
        ticks("ramp", 17);
        vblank_pulse();
        check("ramp17", cache_vec(), 72'd0);
        tick_wait("ramp18_vb", 1'b1);
        check("simul_old", cache_vec(), 72'd0);
        vblank_pulse();
        check("ramp18", cache_vec(), 72'h1);

        // W digit 8 bit 3 (last cell): saturate, release, floor at 0.
        do_reset();
        w_prime_bits = '0;
        w_main_bits  = 36'h8_0000_0000;
        expv         = 72'd1 << cell_pack('{1'b1, 4'd8, 2'd3});
        ticks("sat", 40);
        vblank_pulse();
        check("sat40", cache_vec(), expv);
        w_main_bits = '0;
        ticks("rel", 15);
        vblank_pulse();
        check("rel15", cache_vec(), expv);
        tick_wait("rel16", 1'b0);
        vblank_pulse();
        check("rel16", cache_vec(), 72'd0);
        ticks("floor", 20);
        w_main_bits = 36'h8_0000_0000;
        ticks("reramp", 17);
        vblank_pulse();
        check("reramp17", cache_vec(), 72'd0);
        tick_wait("reramp18", 1'b0);
        vblank_pulse();
        check("reramp18", cache_vec(), expv);

        // Vblank at scan cycle 30: no partial frame reaches the cache.
        do_reset();
        w_prime_bits = 36'h1;
        w_main_bits  = 36'h8_0000_0000;
        expv         = expv | 72'h1;
        ticks("mid", 17);
        vblank_pulse();
        check("mid17", cache_vec(), 72'd0);
        @(negedge clk);
        divider_1khz = 1'b1;
        n            = 0;
        partial_seen = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1)  divider_1khz = 1'b0;
            if (n == 30) vblank_int = 1'b1;
            if (n == 31) vblank_int = 1'b0;
            if (scan_done) break;
            if (cache_vec() != 72'd0) partial_seen = 1'b1;
        end
        check("mid_lat", 72'(n), 72'(LAT));
        check("mid_partial", 72'(partial_seen), 72'd0);
        check("mid_done_cache", cache_vec(), 72'd0);
        @(negedge clk);
        check("mid_after", cache_vec(), expv);

        // Second tick 10 cycles into a scan: overrun, one scan only.
        do_reset();
        w_prime_bits = 36'hF_FFFF_FFFF;
        w_main_bits  = '0;
        @(negedge clk);
        divider_1khz = 1'b1;
        done_cnt     = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1)  divider_1khz = 1'b0;
            if (c == 10) divider_1khz = 1'b1;
            if (c == 20) divider_1khz = 1'b0;
            if (c == 11) check("ovr_set", 72'(overrun), 72'd1);
            if (scan_done) done_cnt++;
        end
        check("ovr_done_cnt", 72'(done_cnt), 72'd1);
        ticks("ovr", 16);
        vblank_pulse();
        check("ovr17", cache_vec(), 72'd0);
        tick_wait("ovr18", 1'b0);
        vblank_pulse();
        check("ovr18", cache_vec(), 72'h0_0000_000F_FFFF_FFFF);
        check("ovr_sticky", 72'(overrun), 72'd1);

        // Reset at scan cycle 50: everything returns to zero at once.
        @(negedge clk);
        divider_1khz = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) divider_1khz = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("mrst_cache", cache_vec(), 72'd0);
        check("mrst_busy", 72'(busy), 72'd0);
        check("mrst_done", 72'(scan_done), 72'd0);
        check("mrst_overrun", 72'(overrun), 72'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks("post", 17);
        vblank_pulse();
        check("post17", cache_vec(), 72'd0);
        tick_wait("post18", 1'b0);
        vblank_pulse();
        check("post18", cache_vec(), 72'h0_0000_000F_FFFF_FFFF);
`else
        // Pass-through: each tick loads W directly, vblank exposes it.
        prevv = 72'd0;
        for (int i = 0; i < 3; i++) begin
            w_prime_bits = pats[i].w_prime;
            w_main_bits  = pats[i].w_main;
            tick_wait($sformatf("pat%0d", i), 1'b0);
            check($sformatf("pat%0d_hold", i), cache_vec(), prevv);
            vblank_pulse();
            prevv = {pats[i].w_main, pats[i].w_prime};
            check($sformatf("pat%0d_cache", i), cache_vec(), prevv);
        end

        // Simultaneous vblank and tick: old work copied, then new work loaded.
        w_prime_bits = 36'h1_2345_6789;
        w_main_bits  = 36'h9_8765_4321;
        tick_wait("simul_a", 1'b0);
        w_prime_bits = 36'h0_F0F0_F0F0;
        w_main_bits  = 36'h3_0000_000C;
        tick_wait("simul_b", 1'b1);
        check("simul_old", cache_vec(), {36'h9_8765_4321, 36'h1_2345_6789});
        vblank_pulse();
        check("simul_new", cache_vec(), {36'h3_0000_000C, 36'h0_F0F0_F0F0});

        // Vblank rising during DONE copies the freshly loaded work.
        w_prime_bits = 36'h5_5555_5555;
        w_main_bits  = 36'hA_AAAA_AAAA;
        @(negedge clk);
        divider_1khz = 1'b1;
        @(negedge clk);
        divider_1khz = 1'b0;
        vblank_int   = 1'b1;
        check("done_pulse", 72'(scan_done), 72'd1);
        check("done_busy", 72'(busy), 72'd0);
        @(negedge clk);
        vblank_int = 1'b0;
        check("done_vb", cache_vec(), {36'hA_AAAA_AAAA, 36'h5_5555_5555});
        check("no_overrun", 72'(overrun), 72'd0);

        // Asynchronous reset clears the cache immediately.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mrst_cache", cache_vec(), 72'd0);
        check("mrst_done", 72'(scan_done), 72'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick_wait("post", 1'b0);
        vblank_pulse();
        check("post_cache", cache_vec(), {36'hA_AAAA_AAAA, 36'h5_5555_5555});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
